// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational 4-bit ALU between two
// requesters (A and B). A winning request is latched onto registered ALU
// inputs; the ALU result is captured one cycle later and returned to the
// owner with a one-cycle done pulse. Sequence is IDLE -> EXEC -> WB -> IDLE.
module alu_share_arbiter #(
  parameter logic [7:0] DIV_ZERO_VAL = 8'hFF,
  parameter bit         ROUND_ROBIN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [3:0] op_a,
  input  logic [3:0] x_a,
  input  logic [3:0] y_a,
  input  logic       req_b,
  input  logic [3:0] op_b,
  input  logic [3:0] x_b,
  input  logic [3:0] y_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] result_a,
  output logic [7:0] result_b,
  output logic       err_a,
  output logic       err_b,
  output logic       busy,
  output logic [3:0] alu_sel,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  input  logic [7:0] alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t     state_q;
  logic       owner_q;       // 0 = A, 1 = B
  logic       last_owner_q;  // owner of the most recently completed operation
  logic       dz_q;          // latched divide/modulo-by-zero flag
  logic       gnt_a_q, gnt_b_q, done_a_q, done_b_q, err_a_q, err_b_q, busy_q;
  logic [7:0] result_a_q, result_b_q;
  logic [3:0] alu_sel_q, alu_x_q, alu_y_q;

  logic       win_b;
  logic [3:0] pick_op, pick_x, pick_y;
  logic       pick_dz;
  logic [7:0] res_eff;

  // Arbitration and operand selection for the IDLE decision, plus the
  // effective result (divide/modulo by zero overrides the ALU output).
  always_comb begin
    win_b = 1'b0;
    if (req_b && !req_a) begin
      win_b = 1'b1;
    end else if (req_a && req_b) begin
      // Round robin: B wins only if A owned the previous operation.
      win_b = ROUND_ROBIN && !last_owner_q;
    end
    pick_op = win_b ? op_b : op_a;
    pick_x  = win_b ? x_b  : x_a;
    pick_y  = win_b ? y_b  : y_a;
    pick_dz = ((pick_op == 4'd3) || (pick_op == 4'd10)) && (pick_y == 4'd0);
    res_eff = dz_q ? DIV_ZERO_VAL : alu_result;
  end

  // Sequencer with all outputs registered; reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      dz_q         <= 1'b0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      done_a_q     <= 1'b0;
      done_b_q     <= 1'b0;
      err_a_q      <= 1'b0;
      err_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      result_a_q   <= 8'h00;
      result_b_q   <= 8'h00;
      alu_sel_q    <= 4'h0;
      alu_x_q      <= 4'h0;
      alu_y_q      <= 4'h0;
    end else begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_a || req_b) begin
            owner_q   <= win_b;
            alu_sel_q <= pick_op;
            alu_x_q   <= pick_x;
            alu_y_q   <= pick_y;
            dz_q      <= pick_dz;
            gnt_a_q   <= !win_b;
            gnt_b_q   <= win_b;
            busy_q    <= 1'b1;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU inputs have been stable for a full cycle; sample its output.
          if (owner_q) begin
            result_b_q <= res_eff;
            err_b_q    <= dz_q;
            done_b_q   <= 1'b1;
          end else begin
            result_a_q <= res_eff;
            err_a_q    <= dz_q;
            done_a_q   <= 1'b1;
          end
          last_owner_q <= owner_q;
          state_q      <= S_WB;
        end
        S_WB: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign done_a   = done_a_q;
  assign done_b   = done_b_q;
  assign err_a    = err_a_q;
  assign err_b    = err_b_q;
  assign busy     = busy_q;
  assign result_a = result_a_q;
  assign result_b = result_b_q;
  assign alu_sel  = alu_sel_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance and a fixed-priority
// instance share the same requester stimulus. Each is paired with a small
// ALU model and checked every cycle against a transaction-level reference.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [3:0] op_a = 4'h0, x_a = 4'h0, y_a = 4'h0;
  logic [3:0] op_b = 4'h0, x_b = 4'h0, y_b = 4'h0;

  logic r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_err_a, r_err_b, r_busy;
  logic [7:0] r_result_a, r_result_b, r_alu_result;
  logic [3:0] r_alu_sel, r_alu_x, r_alu_y;
  logic f_gnt_a, f_gnt_b, f_done_a, f_done_b, f_err_a, f_err_b, f_busy;
  logic [7:0] f_result_a, f_result_b, f_alu_result;
  logic [3:0] f_alu_sel, f_alu_x, f_alu_y;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Stand-in ALU: ops 0..3 and 10 are the arithmetic the arbiter is known to
  // carry; the rest just need to be distinct. Divide by zero yields 00 so
  // the arbiter's override is visible.
  function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] xe, ye;
    xe = {4'h0, x};
    ye = {4'h0, y};
    case (s)
      4'd0:    return xe + ye;
      4'd1:    return xe - ye;
      4'd2:    return xe * ye;
      4'd3:    return (y == 4'd0) ? 8'h00 : xe / ye;
      4'd10:   return (y == 4'd0) ? 8'h00 : xe % ye;
      default: return {x ^ y, s};
    endcase
  endfunction

  assign r_alu_result = alu_f(r_alu_sel, r_alu_x, r_alu_y);
  assign f_alu_result = alu_f(f_alu_sel, f_alu_x, f_alu_y);

  alu_share_arbiter #(.DIV_ZERO_VAL(8'hFF), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .x_a(x_a), .y_a(y_a),
    .req_b(req_b), .op_b(op_b), .x_b(x_b), .y_b(y_b),
    .gnt_a(r_gnt_a), .gnt_b(r_gnt_b), .done_a(r_done_a), .done_b(r_done_b),
    .result_a(r_result_a), .result_b(r_result_b), .err_a(r_err_a), .err_b(r_err_b),
    .busy(r_busy), .alu_sel(r_alu_sel), .alu_x(r_alu_x), .alu_y(r_alu_y),
    .alu_result(r_alu_result));

  alu_share_arbiter #(.DIV_ZERO_VAL(8'hA5), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .x_a(x_a), .y_a(y_a),
    .req_b(req_b), .op_b(op_b), .x_b(x_b), .y_b(y_b),
    .gnt_a(f_gnt_a), .gnt_b(f_gnt_b), .done_a(f_done_a), .done_b(f_done_b),
    .result_a(f_result_a), .result_b(f_result_b), .err_a(f_err_a), .err_b(f_err_b),
    .busy(f_busy), .alu_sel(f_alu_sel), .alu_x(f_alu_x), .alu_y(f_alu_y),
    .alu_result(f_alu_result));

  // Transaction-level reference: an accepted request at edge e produces gnt
  // after e, done/result after e+1, and the next decision happens at e+3.
  typedef struct {
    int         free_at;
    int         gnt_edge;
    int         done_edge;
    bit         owner;
    bit         last_owner;
    logic [7:0] res_a, res_b, pend_res;
    bit         err_a, err_b, pend_err;
    logic [3:0] sel, x, y;
  } model_t;

  model_t m_r, m_f;

  function automatic model_t step(input model_t m, input bit rr, input logic [7:0] dzv);
    model_t n;
    bit b;
    logic [3:0] o, xx, yy;
    n = m;
    if (rst) begin
      n.free_at = k + 1; n.gnt_edge = -10; n.done_edge = -10;
      n.owner = 1'b0; n.last_owner = 1'b1;
      n.res_a = 8'h00; n.res_b = 8'h00; n.err_a = 1'b0; n.err_b = 1'b0;
      n.pend_res = 8'h00; n.pend_err = 1'b0;
      n.sel = 4'h0; n.x = 4'h0; n.y = 4'h0;
      return n;
    end
    if (k == m.done_edge) begin
      if (m.owner) begin n.res_b = m.pend_res; n.err_b = m.pend_err; end
      else         begin n.res_a = m.pend_res; n.err_a = m.pend_err; end
    end
    if (k >= m.free_at && (req_a || req_b)) begin
      b = req_b && (!req_a || (rr && !m.last_owner));
      o  = b ? op_b : op_a;
      xx = b ? x_b  : x_a;
      yy = b ? y_b  : y_a;
      n.owner = b; n.last_owner = b;
      n.sel = o; n.x = xx; n.y = yy;
      n.pend_err = ((o == 4'd3) || (o == 4'd10)) && (yy == 4'd0);
      n.pend_res = n.pend_err ? dzv : alu_f(o, xx, yy);
      n.gnt_edge = k; n.done_edge = k + 1; n.free_at = k + 3;
    end
    return n;
  endfunction

  function automatic logic [34:0] exp_vec(input model_t m);
    bit g, d;
    g = (k == m.gnt_edge);
    d = (k == m.done_edge);
    return {g && !m.owner, g && m.owner, d && !m.owner, d && m.owner,
            m.err_a, m.err_b, g || d, m.res_a, m.res_b, m.sel, m.x, m.y};
  endfunction

  // err is only meaningful alongside its done pulse.
  function automatic logic [34:0] err_mask(input model_t m);
    logic [34:0] mk;
    mk = '1;
    if (!(k == m.done_edge && !m.owner)) mk[30] = 1'b0;
    if (!(k == m.done_edge &&  m.owner)) mk[29] = 1'b0;
    return mk;
  endfunction

  function automatic logic [34:0] r_vec();
    return {r_gnt_a, r_gnt_b, r_done_a, r_done_b, r_err_a, r_err_b, r_busy,
            r_result_a, r_result_b, r_alu_sel, r_alu_x, r_alu_y};
  endfunction

  function automatic logic [34:0] f_vec();
    return {f_gnt_a, f_gnt_b, f_done_a, f_done_b, f_err_a, f_err_b, f_busy,
            f_result_a, f_result_b, f_alu_sel, f_alu_x, f_alu_y};
  endfunction

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, k);
    end
  endtask

  // One clock: advance both references at the edge, compare at the falling edge.
  task automatic tick();
    logic [34:0] mk;
    @(posedge clk);
    k++;
    m_r = step(m_r, 1'b1, 8'hFF);
    m_f = step(m_f, 1'b0, 8'hA5);
    @(negedge clk);
    if (cmp_en) begin
      mk = err_mask(m_r);
      chk("model_rr", r_vec() & mk, exp_vec(m_r) & mk);
      mk = err_mask(m_f);
      chk("model_fp", f_vec() & mk, exp_vec(m_f) & mk);
    end
  endtask

  typedef struct {
    bit         who;      // 0 = A, 1 = B
    logic [3:0] op, x, y;
    logic [7:0] res;
    bit         err;
  } vec_t;

  vec_t vt[9];
  logic [7:0] last_a, last_b;
  int ga, gb, da, db, first_owner, n_g, fa_cnt, fb_cnt;
  int gc[8];
  bit go[8];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", k);
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 4'd2,  4'd15, 4'd15, 8'hE1, 1'b0};
    vt[1] = '{1'b0, 4'd1,  4'd3,  4'd5,  8'hFE, 1'b0};
    vt[2] = '{1'b0, 4'd3,  4'd9,  4'd0,  8'hFF, 1'b1};
    vt[3] = '{1'b0, 4'd10, 4'd9,  4'd4,  8'h01, 1'b0};
    vt[4] = '{1'b1, 4'd3,  4'd7,  4'd0,  8'hFF, 1'b1};
    vt[5] = '{1'b1, 4'd10, 4'd13, 4'd0,  8'hFF, 1'b1};
    vt[6] = '{1'b0, 4'd0,  4'd15, 4'd15, 8'h1E, 1'b0};
    vt[7] = '{1'b1, 4'd1,  4'd0,  4'd1,  8'hFF, 1'b0};
    vt[8] = '{1'b0, 4'd3,  4'd15, 4'd4,  8'h03, 1'b0};

    // Reset
    @(negedge clk);
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_rr", r_vec(), 35'h0);
    chk("reset_fp", f_vec(), 35'h0);
    rst = 1'b0;

    // First A operation: 7 + 5
    req_a = 1'b1; op_a = 4'd0; x_a = 4'd7; y_a = 4'd5;
    tick();
    chk("seq1_gnt_busy", {33'h0, r_gnt_a, r_busy}, {33'h0, 2'b11});
    req_a = 1'b0; op_a = 4'd9; x_a = 4'd1; y_a = 4'd1;
    tick();
    chk("seq1_done", {17'h0, r_done_a, r_err_a, r_busy, r_result_a, r_result_b},
                     {17'h0, 1'b1, 1'b0, 1'b1, 8'h0C, 8'h00});
    tick();
    chk("seq1_idle", {33'h0, r_busy, r_done_a}, 35'h0);
    last_a = 8'h0C; last_b = 8'h00;

    // Table of single-requester operations
    for (int i = 0; i < 9; i++) begin
      if (vt[i].who) begin req_b = 1'b1; op_b = vt[i].op; x_b = vt[i].x; y_b = vt[i].y; end
      else           begin req_a = 1'b1; op_a = vt[i].op; x_a = vt[i].x; y_a = vt[i].y; end
      tick();
      req_a = 1'b0; req_b = 1'b0;
      tick();
      if (vt[i].who) begin
        chk($sformatf("vec%0d_b", i), {8'h0, r_done_b, r_err_b, r_result_b, r_result_a},
            {8'h0, 1'b1, vt[i].err, vt[i].res, last_a});
        last_b = vt[i].res;
      end else begin
        chk($sformatf("vec%0d_a", i), {8'h0, r_done_a, r_err_a, r_result_a, r_result_b},
            {8'h0, 1'b1, vt[i].err, vt[i].res, last_b});
        last_a = vt[i].res;
      end
      tick();
    end

    // Contention right after reset: A first, then B
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 1'b1; op_a = 4'd0; x_a = 4'd1; y_a = 4'd1;
    req_b = 1'b1; op_b = 4'd0; x_b = 4'd2; y_b = 4'd2;
    ga = -1; gb = -1; da = -1; db = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (r_gnt_a)  begin req_a = 1'b0; ga = i; end
      if (r_gnt_b)  begin req_b = 1'b0; gb = i; end
      if (r_done_a) da = i;
      if (r_done_b) db = i;
    end
    chk("contend_timing", {3'h0, ga[7:0], da[7:0], gb[7:0], db[7:0]},
        {3'h0, 8'd1, 8'd2, 8'd4, 8'd5});
    chk("contend_results", {19'h0, r_result_a, r_result_b}, {19'h0, 8'h02, 8'h04});

    // Both again: A must be next after B
    req_a = 1'b1; req_b = 1'b1;
    first_owner = -1;
    for (int i = 0; i < 6 && first_owner < 0; i++) begin
      tick();
      if (r_gnt_a) first_owner = 0;
      else if (r_gnt_b) first_owner = 1;
    end
    chk("alternate_next", 35'(first_owner), 35'd0);
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();

    // Continuous contention: round robin alternates, fixed priority starves B
    req_a = 1'b1; req_b = 1'b1;
    n_g = 0; fa_cnt = 0; fb_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if ((r_gnt_a || r_gnt_b) && n_g < 8) begin gc[n_g] = i; go[n_g] = r_gnt_b; n_g++; end
      if (f_gnt_a) fa_cnt++;
      if (f_gnt_b) fb_cnt++;
    end
    chk("rr_count", 35'(n_g), 35'd5);
    for (int j = 0; j < n_g && j < 5; j++)
      chk($sformatf("rr_gnt%0d", j), {26'h0, go[j], gc[j][7:0]},
          {26'h0, (j % 2 == 0), 8'(1 + 3 * j)});
    chk("fp_counts", {3'h0, fa_cnt[15:0], fb_cnt[15:0]}, {3'h0, 16'd5, 16'd0});
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick(); tick();

    // Reset during EXEC abandons the operation
    req_a = 1'b1; op_a = 4'd0; x_a = 4'd7; y_a = 4'd5;
    tick();
    chk("abort_gnt", {34'h0, r_gnt_a}, 35'h1);
    req_a = 1'b0; rst = 1'b1;
    tick();
    chk("abort_clear_rr", r_vec(), 35'h0);
    chk("abort_clear_fp", f_vec(), 35'h0);
    rst = 1'b0;
    tick();
    chk("abort_no_done", {33'h0, r_done_a, r_busy}, 35'h0);
    req_b = 1'b1; op_b = 4'd0; x_b = 4'd1; y_b = 4'd2;
    tick();
    chk("abort_gnt_b", {34'h0, r_gnt_b}, 35'h1);
    req_b = 1'b0;
    tick();
    chk("abort_done_b", {26'h0, r_done_b, r_result_b}, {26'h0, 1'b1, 8'h03});
    tick();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      req_a = $urandom_range(0, 2) != 0;
      req_b = $urandom_range(0, 2) != 0;
      op_a  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 4'd3 : 4'd10) : 4'($urandom);
      op_b  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 4'd3 : 4'd10) : 4'($urandom);
      x_a   = 4'($urandom);
      x_b   = 4'($urandom);
      y_a   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      y_b   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      tick();
    end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 4-bit combinational ALU datapath between two independent requesters (A and B) with round-robin arbitration. It latches a requester's opcode and operands, drives them onto the ALU inputs from registers, and captures the 8-bit ALU result. It then returns the result to the owning requester with a one-cycle done pulse. It sits between requester logic and the ALU instance. The ALU itself stays purely combinational and outside this block.

Parameters:
DIV_ZERO_VAL, 8'hFF, result returned for divide (op 3) or modulo (op 10) when y == 0
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, A always wins

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
req_a  input  1  requester A request (level); sampled only in IDLE
op_a  input  4  requester A ALU select code (0..15, same encoding as ALU sel)
x_a  input  4  requester A operand x
y_a  input  4  requester A operand y
req_b, op_b, x_b, y_b  input  1/4/4/4  requester B, same meaning
gnt_a  output  1  one-cycle pulse: A's request accepted and operands latched
gnt_b  output  1  one-cycle pulse for B
done_a  output  1  one-cycle pulse: result_a valid
done_b  output  1  one-cycle pulse for B
result_a  output  8  last result for A; held until A's next done
result_b  output  8  last result for B; held until B's next done
err_a  output  1  valid with done_a; 1 = divide/modulo by zero
err_b  output  1  valid with done_b
busy  output  1  high in EXEC and WB
alu_sel  output  4  to ALU select input (registered)
alu_x  output  4  to ALU x operand (registered)
alu_y  output  4  to ALU y operand (registered)
alu_result  input  8  from ALU combinational output

Behaviour:
- Reset (rst high at a rising edge): state = IDLE; last_owner = B, so A wins the first contention.
- Reset values: all gnt/done/err = 0; result_a = result_b = 0; alu_sel = alu_x = alu_y = 0; busy = 0.
- Reset takes priority over all other activity.
- FSM states: IDLE -> EXEC -> WB -> IDLE. All outputs are registered.
- IDLE, no request: remain in IDLE.
- IDLE, exactly one request: that requester wins.
- IDLE, both requests: with ROUND_ROBIN=1 the requester other than last_owner wins; with ROUND_ROBIN=0, A wins.
- On winning: latch owner, op, x and y into alu_sel/alu_x/alu_y; compute dz = (op==3 || op==10) && y==0; go to EXEC.
- EXEC (1 cycle): gnt_<owner> = 1, busy = 1. At the end of the cycle, capture res = dz ? DIV_ZERO_VAL : alu_result; go to WB.
- WB (1 cycle): done_<owner> = 1, err_<owner> = dz, result_<owner> = res. The other requester's result is unchanged. Set last_owner = owner; go to IDLE.
- Latency: req sampled in IDLE at cycle t -> gnt at t+1 -> done/result at t+2 -> IDLE at t+3. Throughput is one operation per 3 cycles.
- Requesters must drop req on seeing gnt. A req still high in the next IDLE cycle is treated as a new request.
- req and operands are ignored outside IDLE, so operands may change freely after gnt.
- alu_sel/alu_x/alu_y hold their last values while in IDLE. The ALU output is only sampled in EXEC.
- Reset asserted in EXEC or WB: the operation is abandoned and no done is issued. Results clear to 0 and the FSM is in IDLE on the next cycle.
- Width: alu_result is passed through unmodified. Signed subtraction arrives two's-complement from the ALU, e.g. 3-5 = 8'hFE.

Test Plan:
- Reset, then req_a=1 with op=0, x=7, y=5 in cycle t -> gnt_a at t+1; done_a at t+2 with result_a=8'h0C, err_a=0; busy high for t+1..t+2; result_b stays 0.
- req_b with op=2, x=15, y=15 -> done_b with result_b=8'hE1. Then A issues op=1, x=3, y=5 -> result_a=8'hFE, and result_b still 8'hE1.
- Both req high in the first cycle after reset, held until their own gnt -> A granted first (done_a at t+2), B granted at t+4 (done_b at t+5). Repeat with both high again -> A is served next, confirming alternation.
- Both req held continuously -> A and B strictly alternate every 3 cycles. Repeat with ROUND_ROBIN=0 -> A is served every time and B starves.
- op_a=3, x=9, y=0 -> result_a=8'hFF, err_a=1. Then op_a=10, x=9, y=4 -> result_a=8'h01, err_a=0.
- Assert rst for one cycle during EXEC of an A op -> no done_a; all outputs 0 the next cycle; a new req_b is accepted normally afterwards.
